// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
//   Shared types and helpers for the packet-aware round-robin arbiter that
//   feeds a pipeline_fifo write port.
//   Contents:
//     arb_state_t : arbiter FSM encoding (IDLE = free to pick, LOCKED = packet
//                   in flight, grant held by the owner)
//     rr_next()   : modulo-n increment used to rotate the priority pointer.
//                   It is correct for non-power-of-2 requester counts.
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Modulo increment. A plain width-truncating add would wrap correctly only
    // when n is a power of two.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// -----------------------------------------------------------------------------
// rr_priority_select
//   Combinational rotating find-first-set. The scan starts at index ptr and
//   continues at ptr+1, ... (mod NUM_REQ). It returns the first requester that
//   has req_val set.
//   Ports:
//     req_val  in   NUM_REQ  per-requester valid
//     ptr      in   ID_W     highest-priority index
//     winner   out  ID_W     first valid index at or after ptr (0 if none)
//     any_val  out  1        at least one req_val bit set
// -----------------------------------------------------------------------------
module rr_priority_select #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_val,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    winner,
    output logic               any_val
);

    logic [ID_W-1:0] idx;

    // The scan walks from the lowest priority (farthest from ptr) to the
    // highest. The last hit therefore wins, and the loop needs no early exit.
    always_comb begin
        // NOTE: every output of a combinational block is given a default before
        // any conditional assignment. This prevents latch inference.
        winner  = '0;
        any_val = 1'b0;
        idx     = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            if (int'(ptr) + off >= NUM_REQ) begin
                idx = ID_W'(int'(ptr) + off - NUM_REQ);
            end else begin
                idx = ID_W'(int'(ptr) + off);
            end
            if (req_val[idx]) begin
                winner  = idx;
                any_val = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_rr_arbiter
//   Packet-aware round-robin arbiter. It shares one pipeline_fifo write port
//   among NUM_REQ requesters.
//   - When the first beat of a packet is accepted, the grant stays with that
//     requester until its last beat is accepted.
//   - Priority then rotates to the index after the owner.
//   - The data path is a zero-latency pass-through with no data register.
//   Ports:
//     clk       in   1                   clock
//     arst_n    in   1                   async active-low reset
//     req_data  in   NUM_REQ*ELEM_WIDTH  requester i beat at [i*ELEM_WIDTH +: ELEM_WIDTH]
//     req_val   in   NUM_REQ             per-requester beat valid
//     req_last  in   NUM_REQ             per-requester last beat of packet
//     req_rdy   out  NUM_REQ             per-requester ready (one-hot or zero)
//     out_data  out  ELEM_WIDTH          selected beat to the FIFO
//     out_val   out  1                   selected beat valid
//     out_rdy   in   1                   FIFO ready (= !full)
//     out_src   out  ID_W                index of the granted requester
//     busy      out  1                   packet in flight (state LOCKED)
// -----------------------------------------------------------------------------
module fifo_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int ELEM_WIDTH = 32,
    parameter  int NUM_REQ    = 4,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic [NUM_REQ*ELEM_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_val,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_rdy,
    output logic [ELEM_WIDTH-1:0]         out_data,
    output logic                          out_val,
    input  logic                          out_rdy,
    output logic [ID_W-1:0]               out_src,
    output logic                          busy
);

    arb_state_t      state_q, state_d;
    logic [ID_W-1:0] owner_q, owner_d;
    logic [ID_W-1:0] ptr_q,   ptr_d;

    logic [ID_W-1:0]       sel_winner;
    logic                  sel_any;
    logic [ID_W-1:0]       winner;
    logic                  accept;
    logic [ELEM_WIDTH-1:0] beats [NUM_REQ];

    // Unpack the flat data bus so the output mux is a plain array index.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign beats[i] = req_data[i*ELEM_WIDTH +: ELEM_WIDTH];
    end

    rr_priority_select #(
        .NUM_REQ (NUM_REQ)
    ) u_select (
        .req_val (req_val),
        .ptr     (ptr_q),
        .winner  (sel_winner),
        .any_val (sel_any)
    );

    // While a packet is in flight, the owner keeps the grant. Other requesters
    // are ignored, even when the owner has a bubble.
    assign winner = (state_q == ARB_LOCKED) ? owner_q : sel_winner;
    assign accept = out_val && out_rdy;

    // State register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments. All
            // registers then update together from the pre-edge values.
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic. Nothing moves unless a beat is accepted, so a
    // back-pressured or bubbling packet never loses its grant.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (accept) begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (req_last[winner]) begin
                        // This is a single-beat packet. Rotate past the winner
                        // at once.
                        ptr_d = ID_W'(rr_next(int'(winner), NUM_REQ));
                    end else begin
                        state_d = ARB_LOCKED;
                        owner_d = winner;
                    end
                end
                ARB_LOCKED: begin
                    if (req_last[owner_q]) begin
                        state_d = ARB_IDLE;
                        ptr_d   = ID_W'(rr_next(int'(owner_q), NUM_REQ));
                    end
                end
                default: begin
                    state_d = ARB_IDLE;
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        out_val  = (state_q == ARB_LOCKED) ? req_val[owner_q] : sel_any;
        out_data = beats[winner];
        out_src  = winner;
        req_rdy  = '0;
        req_rdy[winner] = out_rdy && out_val;
    end

    assign busy = (state_q == ARB_LOCKED);

    // Protocol invariants
    a_rdy_onehot0 : assert property (@(posedge clk) disable iff (!arst_n)
        $onehot0(req_rdy));

    a_src_stable : assert property (@(posedge clk) disable iff (!arst_n)
        (busy && $past(busy)) |-> $stable(out_src));

    a_val_known : assert property (@(posedge clk) disable iff (!arst_n)
        !$isunknown(out_val));

endmodule
